// File: rtl/hbridge_driver_if.sv
// Command/status bundle between the motion modules and the H-bridge driver.
// The master side issues commands; the slave side (the driver) returns pin states.
`timescale 1ns/1ps
interface hbridge_driver_if;
    logic [3:0] ins_cmd;
    logic [1:0] enables_in;
    logic [7:0] duty;
    logic [3:0] ins_out;
    logic [1:0] en_pwm;
    logic       busy;
    logic       fault;

    modport master (
        output ins_cmd, enables_in, duty,
        input  ins_out, en_pwm, busy, fault
    );

    modport slave (
        input  ins_cmd, enables_in, duty,
        output ins_out, en_pwm, busy, fault
    );
endinterface

// File: rtl/hbridge_driver.sv
// H-bridge pin driver: filters illegal IN codes, inserts dead time on direction
// reversal and gates the EN pins with an 8-bit PWM.
`timescale 1ns/1ps
module hbridge_driver #(
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    hbridge_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        DRIVE   = 2'd1,
        DEAD    = 2'd2
    } stateT;

    localparam logic [3:0] CODE_INERTIAL = 4'b0000;
    localparam logic [3:0] CODE_HARD     = 4'b1111;
    localparam logic [7:0] DEAD_LOAD     = 8'(DEAD_CYCLES - 1);

    stateT      stateReg, stateNext;
    logic [3:0] pendingReg, pendingNext;
    logic [7:0] deadCntReg, deadCntNext;
    logic [7:0] pwmCntReg, pwmCntNext;
    logic [7:0] dutyReg, dutyNext;
    logic [3:0] insOutReg, insOutNext;
    logic [1:0] enPwmReg, enPwmNext;
    logic       busyReg, busyNext;
    logic       faultReg, faultNext;

    logic       cmdLegal;
    logic       cmdIsStop;
    logic [3:0] cmdClean;
    logic       pwmOn;

    always_comb begin
        cmdLegal = 1'b0;
        case (bus.ins_cmd)
            4'b0000, 4'b1111, 4'b1001, 4'b0110, 4'b0101, 4'b1010: cmdLegal = 1'b1;
            default: cmdLegal = 1'b0;
        endcase
        cmdClean  = cmdLegal ? bus.ins_cmd : CODE_INERTIAL;
        cmdIsStop = (cmdClean == CODE_INERTIAL) || (cmdClean == CODE_HARD);
    end

    // PWM decisions use the post-edge counter/duty so en_pwm lines up with
    // the pwm count that is current while the output is visible.
    always_comb begin
        pwmCntNext = pwmCntReg + 8'd1;
        dutyNext   = (pwmCntReg == 8'hFF) ? bus.duty : dutyReg;
        if (dutyNext == 8'd0)
            pwmOn = 1'b0;
        else if (dutyNext == 8'hFF)
            pwmOn = 1'b1;
        else
            pwmOn = (pwmCntNext < dutyNext);
    end

    always_comb begin
        stateNext   = stateReg;
        pendingNext = pendingReg;
        deadCntNext = deadCntReg;
        insOutNext  = insOutReg;
        enPwmNext   = 2'b00;
        busyNext    = 1'b0;
        faultNext   = faultReg | ~cmdLegal;

        if (cmdIsStop) begin
            // Stop codes win from every state, abandoning any dead interval.
            stateNext   = STOPPED;
            insOutNext  = cmdClean;
            pendingNext = CODE_INERTIAL;
            deadCntNext = 8'd0;
        end else begin
            case (stateReg)
                STOPPED: begin
                    stateNext  = DRIVE;
                    insOutNext = cmdClean;
                end
                DRIVE: begin
                    if (cmdClean != insOutReg) begin
                        stateNext   = DEAD;
                        pendingNext = cmdClean;
                        deadCntNext = DEAD_LOAD;
                        insOutNext  = CODE_INERTIAL;
                    end
                end
                DEAD: begin
                    // Newest drive request replaces the pending one; the count keeps running.
                    pendingNext = cmdClean;
                    if (deadCntReg == 8'd0) begin
                        stateNext  = DRIVE;
                        insOutNext = pendingNext;
                    end else begin
                        deadCntNext = deadCntReg - 8'd1;
                        insOutNext  = CODE_INERTIAL;
                    end
                end
                default: begin
                    stateNext  = STOPPED;
                    insOutNext = CODE_INERTIAL;
                end
            endcase
        end

        case (stateNext)
            STOPPED: enPwmNext = (insOutNext == CODE_HARD) ? bus.enables_in : 2'b00;
            DRIVE:   enPwmNext = bus.enables_in & {2{pwmOn}};
            DEAD:    busyNext  = 1'b1;
            default: enPwmNext = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg   <= STOPPED;
            pendingReg <= 4'b0000;
            deadCntReg <= 8'd0;
            pwmCntReg  <= 8'd0;
            dutyReg    <= 8'd0;
            insOutReg  <= 4'b0000;
            enPwmReg   <= 2'b00;
            busyReg    <= 1'b0;
            faultReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pendingReg <= pendingNext;
            deadCntReg <= deadCntNext;
            pwmCntReg  <= pwmCntNext;
            dutyReg    <= dutyNext;
            insOutReg  <= insOutNext;
            enPwmReg   <= enPwmNext;
            busyReg    <= busyNext;
            faultReg   <= faultNext;
        end
    end

    assign bus.ins_out = insOutReg;
    assign bus.en_pwm  = enPwmReg;
    assign bus.busy    = busyReg;
    assign bus.fault   = faultReg;

endmodule

// File: tb/tb_hbridge_driver.sv
// Bench for hbridge_driver: time-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_hbridge_driver;

    localparam int DEAD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hbridge_driver_if dif();

    hbridge_driver #(.DEAD_CYCLES(DEAD)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: elapsed cycles since reset give the pwm count directly.
    int         mCyc = 0;
    int         mMode = 0;        // 0 stopped, 1 driving, 2 dead time
    int         mDeadStart = 0;
    logic [3:0] mCode = 4'h0;
    logic [3:0] mPend = 4'h0;
    logic [7:0] mDuty = 8'h0;
    logic       mFault = 1'b0;
    logic [3:0] expIns = 4'h0;
    logic [1:0] expEn = 2'b00;
    logic       expBusy = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] c;
        int         pwm;
        logic       on;
        if (rst) begin
            mCyc = 0; mMode = 0; mCode = 4'h0; mPend = 4'h0; mDuty = 8'h0; mFault = 1'b0;
        end else begin
            if (mCyc % 256 == 255) mDuty = dif.duty;
            mCyc++;
            c = dif.ins_cmd;
            if (!(c inside {4'h0, 4'hF, 4'h9, 4'h6, 4'h5, 4'hA})) begin
                mFault = 1'b1;
                c = 4'h0;
            end
            if (c == 4'h0 || c == 4'hF) begin
                mMode = 0; mCode = c;
            end else if (mMode == 0) begin
                mMode = 1; mCode = c;
            end else if (mMode == 1) begin
                if (c != mCode) begin
                    mMode = 2; mPend = c; mDeadStart = mCyc;
                end
            end else begin
                mPend = c;
                if (mCyc - mDeadStart >= DEAD) begin
                    mMode = 1; mCode = mPend;
                end
            end
        end
        pwm = mCyc % 256;
        on  = (mDuty == 8'd0) ? 1'b0 : (mDuty == 8'd255) ? 1'b1 : (pwm < int'(mDuty));
        expBusy = (mMode == 2);
        expIns  = (mMode == 2) ? 4'h0 : mCode;
        if (mMode == 0)      expEn = (mCode == 4'hF) ? dif.enables_in : 2'b00;
        else if (mMode == 1) expEn = dif.enables_in & {2{on}};
        else                 expEn = 2'b00;
        #1;
        chk("cyc_ins_out", 8'(dif.ins_out), 8'(expIns));
        chk("cyc_en_pwm",  8'(dif.en_pwm),  8'(expEn));
        chk("cyc_busy",    8'(dif.busy),    8'(expBusy));
        chk("cyc_fault",   8'(dif.fault),   8'(mFault));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitPwm(input int target);
        int i;
        i = 0;
        while ((mCyc % 256) != target && i < 600) begin
            tick();
            i++;
        end
        if (i >= 600) chk("wait_pwm_timeout", 8'(mCyc % 256), 8'(target));
    endtask

    logic [3:0] legalTab [6] = '{4'h0, 4'hF, 4'h9, 4'h6, 4'h5, 4'hA};

    initial begin
        int n;
        int bad;
        dif.ins_cmd = 4'h0; dif.enables_in = 2'b00; dif.duty = 8'd0;
        rst = 1'b1;
        ticks(2);
        chk("reset_ins_out", 8'(dif.ins_out), 8'h0);
        chk("reset_en_pwm",  8'(dif.en_pwm),  8'h0);
        chk("reset_busy",    8'(dif.busy),    8'h0);
        chk("reset_fault",   8'(dif.fault),   8'h0);
        rst = 1'b0;

        // Forward at half duty.
        dif.ins_cmd = 4'b1001; dif.enables_in = 2'b11; dif.duty = 8'd128;
        tick();
        chk("fwd_latency", 8'(dif.ins_out), 8'h9);
        chk("fwd_busy",    8'(dif.busy),    8'h0);
        n = 0;
        while (mCyc < 261 && n < 400) begin tick(); n++; end
        chk("pwm128_at5",   8'(dif.en_pwm), 8'h3);
        waitPwm(127);
        chk("pwm128_at127", 8'(dif.en_pwm), 8'h3);
        tick();
        chk("pwm128_at128", 8'(dif.en_pwm), 8'h0);

        // Reversal with full dead interval.
        dif.ins_cmd = 4'b0110;
        tick();
        chk("dead_ins_out", 8'(dif.ins_out), 8'h0);
        chk("dead_en_pwm",  8'(dif.en_pwm),  8'h0);
        chk("dead_busy",    8'(dif.busy),    8'h1);
        n = 1;
        for (int i = 0; i < 100 && dif.busy; i++) begin
            tick();
            if (dif.busy) n++;
        end
        chk("dead_length",  8'(n), 8'(DEAD));
        chk("dead_exit_ins", 8'(dif.ins_out), 8'h6);
        chk("dead_exit_busy", 8'(dif.busy), 8'h0);

        // Back to forward, then reverse with mid-dead overrides ending in hard stop.
        dif.ins_cmd = 4'b1001;
        ticks(20);
        chk("refwd_ins_out", 8'(dif.ins_out), 8'h9);
        dif.enables_in = 2'b10;
        dif.ins_cmd = 4'b0110;
        ticks(4);
        dif.ins_cmd = 4'b0101;
        ticks(4);
        chk("override_busy", 8'(dif.busy), 8'h1);
        dif.ins_cmd = 4'b1111;
        tick();
        chk("hard_ins_out", 8'(dif.ins_out), 8'hF);
        chk("hard_en_pwm",  8'(dif.en_pwm),  8'h2);
        chk("hard_busy",    8'(dif.busy),    8'h0);

        // Illegal code sets sticky fault.
        dif.ins_cmd = 4'b0011;
        tick();
        chk("illegal_ins_out", 8'(dif.ins_out), 8'h0);
        chk("illegal_fault",   8'(dif.fault),   8'h1);
        dif.ins_cmd = 4'b1001;
        ticks(3);
        chk("fault_sticky",  8'(dif.fault),   8'h1);
        chk("after_fault_ins", 8'(dif.ins_out), 8'h9);
        rst = 1'b1;
        tick();
        chk("fault_cleared", 8'(dif.fault), 8'h0);
        rst = 1'b0;

        // Duty extremes and period-aligned duty update.
        dif.enables_in = 2'b11; dif.duty = 8'd0; dif.ins_cmd = 4'b1001;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dif.en_pwm != 2'b00) bad++;
        end
        chk("duty0_en_count", 8'(bad), 8'h0);
        dif.duty = 8'd255;
        waitPwm(0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (dif.en_pwm != 2'b11) bad++;
        end
        chk("duty255_off_count", 8'(bad), 8'h0);
        waitPwm(40);
        dif.duty = 8'd64;
        tick();
        chk("duty_change_41",  8'(dif.en_pwm), 8'h3);
        waitPwm(100);
        chk("duty_change_100", 8'(dif.en_pwm), 8'h3);
        waitPwm(10);
        chk("duty64_at10",  8'(dif.en_pwm), 8'h3);
        waitPwm(100);
        chk("duty64_at100", 8'(dif.en_pwm), 8'h0);

        // Reset during dead time.
        dif.ins_cmd = 4'b0110;
        ticks(7);
        chk("pre_reset_busy", 8'(dif.busy), 8'h1);
        rst = 1'b1;
        tick();
        chk("rst_dead_ins", 8'(dif.ins_out), 8'h0);
        chk("rst_dead_en",  8'(dif.en_pwm),  8'h0);
        chk("rst_dead_busy", 8'(dif.busy),   8'h0);
        rst = 1'b0;
        dif.ins_cmd = 4'b0000;
        ticks(20);
        chk("post_rst_ins",  8'(dif.ins_out), 8'h0);
        chk("post_rst_busy", 8'(dif.busy),    8'h0);
        dif.ins_cmd = 4'b0101;
        tick();
        chk("post_rst_drive", 8'(dif.ins_out), 8'h5);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       dif.ins_cmd = 4'($urandom_range(0, 15));
            else if (r < 12) dif.ins_cmd = legalTab[$urandom_range(0, 5)];
            if ($urandom_range(0, 19) == 0) dif.enables_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) dif.duty = 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 999) < 2);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hbridge_driver.md
HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 16, meaning the number of clocks both bridges are held off on a drive-direction change (legal range 1..255).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port ins_cmd  input  4  requested H-bridge IN code from the motion modules.
REQ-005 SHALL have port enables_in  input  2  per-motor enable request; [1]=motor A (IN[3:2]), [0]=motor B (IN[1:0]).
REQ-006 SHALL have port duty  input  8  PWM duty request, 0..255.
REQ-007 SHALL have port ins_out  output  4  registered IN pins to the H-bridge.
REQ-008 SHALL have port en_pwm  output  2  registered EN pins to the H-bridge, same bit mapping as enables_in.
REQ-009 SHALL have port busy  output  1  high while a dead-time interval is in progress.
REQ-010 SHALL have port fault  output  1  sticky flag: an illegal ins_cmd was sampled.

Function
REQ-011 SHALL treat as legal only: 0000 INERTIAL_STOP, 1111 HARD_STOP, 1001 FORWARD, 0110 REVERSE, 0101 TURN_RIGHT, 1010 TURN_LEFT; drive codes are the last four.
REQ-012 SHALL replace any illegal ins_cmd with 0000 and set fault on the next clock; fault clears only on reset.
REQ-013 SHALL implement states STOPPED, DRIVE, DEAD; STOPPED covers both stop codes.
REQ-014 SHALL, with no dead time required, update ins_out exactly 1 clock after ins_cmd is sampled.
REQ-015 SHALL go STOPPED->DRIVE immediately (1-clock latency) when a drive code arrives.
REQ-016 SHALL go any state->STOPPED immediately when a stop code arrives, including mid-DEAD, aborting the dead count.
REQ-017 SHALL, in DRIVE, on a change to a different drive code, enter DEAD: ins_out=0000, en_pwm=00, busy=1 for exactly DEAD_CYCLES clocks, then enter DRIVE with the pending code.
REQ-018 SHALL, in DEAD, overwrite the pending code with every newly sampled drive code without restarting the dead counter.
REQ-019 SHALL, if the pending code at DEAD expiry equals the code active before DEAD, still complete the full dead interval.
REQ-020 SHALL in HARD_STOP drive ins_out=1111 and en_pwm=enables_in (no PWM, full brake); in INERTIAL_STOP ins_out=0000, en_pwm=00.
REQ-021 SHALL keep a free-running 8-bit pwm_cnt that increments every clock and wraps 255->0, running in all states.
REQ-022 SHALL latch duty into duty_reg only when pwm_cnt==255, so a duty change takes effect at the next period start.
REQ-023 SHALL in DRIVE set en_pwm[i] = enables_in[i] AND pwm_on, with pwm_on = 0 if duty_reg==0, 1 if duty_reg==255, else (pwm_cnt < duty_reg).
REQ-024 SHALL never drive ins_out to a code outside the legal set of REQ-011.
REQ-025 SHALL deassert busy on the same clock that ins_out takes the pending code.

Reset
REQ-026 SHALL on reset set ins_out=0000, en_pwm=00, busy=0, fault=0, pwm_cnt=0, duty_reg=0, pending=0000, dead counter=0, state STOPPED.
REQ-027 SHALL, when reset is asserted mid-DEAD or mid-DRIVE, reach the REQ-026 values on the next clock; no pending code survives reset.
REQ-028 SHALL, after reset deasserts, sample ins_cmd normally on the next clock.

Verification
REQ-029 SHALL cover: reset, ins_cmd=1001, enables_in=11, duty=128 -> ins_out=1001 one clock later; once duty_reg loads (first pwm_cnt==255), en_pwm=11 for pwm_cnt 0..127 and 00 for 128..255.
REQ-030 SHALL cover: DRIVE 1001, switch to 0110 -> ins_out=0000, en_pwm=00, busy=1 for 16 clocks, then ins_out=0110, busy=0.
REQ-031 SHALL cover: in DEAD after 1001->0110, apply 0101 at dead clock 5 then 1111 at clock 9 -> ins_out=1111, en_pwm=enables_in, busy=0 on the next clock.
REQ-032 SHALL cover: ins_cmd=0011 -> ins_out=0000, fault=1 next clock; fault stays 1 after legal codes until reset.
REQ-033 SHALL cover: duty=0 -> en_pwm=00 throughout DRIVE; duty=255 -> en_pwm=enables_in constantly; duty change at pwm_cnt=40 applies only after pwm_cnt wraps.
REQ-034 SHALL cover: reset asserted at dead clock 7 -> all REQ-026 values next clock, ins_out stays 0000 until a new drive code.
